norm_seq: RTL
=============

Name: norm_seq

Overview:
- Row sequencer that drives the normalization stage (acc/div) of one core.
- Per row: reads an 8-column psum row from psum SRAM and pulses acc to latch the row |sum|. Then rendezvouses with the peer core so both row sums are valid, rereads the row, pulses div, and writes the normalized row to output SRAM.
- Sits between psum SRAM and the normalization stage; output SRAM receives that stage's sfp_out.

Parameters:
- addr_bw, 4, SRAM address width; max rows = 2**addr_bw.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a pass when idle
- num_rows  in  addr_bw+1  rows to process, latched on accepted start
- solo  in  1  1 = single-core mode, skip peer rendezvous; latched on start
- psum_cen  out  1  psum SRAM chip enable, active-low
- psum_addr  out  addr_bw  psum SRAM read address
- acc  out  1  norm accumulate strobe
- div  out  1  norm divide strobe
- out_cen  out  1  output SRAM chip enable, active-low
- out_wen  out  1  output SRAM write enable, active-low
- out_addr  out  addr_bw  output SRAM write address
- tok_out  out  1  row token to peer core
- tok_in  in  1  row token from peer core
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values:
  - outputs: psum_cen=1, out_cen=1, out_wen=1, acc=0, div=0, tok_out=0, busy=0, done=0, addresses=0.
  - internal: row counter=0, state=IDLE.
- All outputs registered; psum SRAM read latency is 1 cycle, so data is on sfp_in the cycle after psum_cen=0.
- States and transitions:
  - IDLE: on start → latch num_rows and solo, row=0, busy=1.
    - If num_rows==0 → DONE.
    - Else → RD_ACC.
    - start while busy is ignored.
  - RD_ACC: psum_cen=0, psum_addr=row → ACC.
  - ACC: acc=1 (row data present) → SYNC; tok_out toggles on this transition, the same edge the norm stage latches its sum.
  - SYNC: wait until tok_in==tok_out (or solo=1) → RD_DIV.
    - Minimum 1 cycle in SYNC.
    - Wait is unbounded; no timeout.
  - RD_DIV: psum_cen=0, psum_addr=row → DIV.
  - DIV: div=1; the norm stage registers sfp_out at the end of this cycle → WR.
  - WR: out_cen=0, out_wen=0, out_addr=row.
    - If row==num_rows-1 → DONE.
    - Else row+1 → RD_ACC.
  - DONE: done=1, busy drops with it → IDLE.
- Strobe exclusivity: acc and div are never high in the same cycle; outside their states they are 0.
- Throughput: 6 cycles/row with the peer in lockstep. Pass latency from start = 6*num_rows+2 cycles to the done pulse.
- Token rendezvous:
  - Toggle (2-phase) protocol; tolerates up to 1 cycle skew between cores.
  - The peer's next ACC occurs ≥4 cycles after the match, while the local DIV occurs ≤3 cycles after the match, so sum_other_core is stable during div.
- num_rows > 2**addr_bw is clamped to 2**addr_bw.
- Reset mid-pass:
  - Immediate return to IDLE, tok_out=0, no further SRAM access.
  - Both cores must be reset together.
- start coincident with reset: reset wins.

Decomposition:
- Shared package: state encoding constants (IDLE, RD_ACC, ACC, SYNC, RD_DIV, DIV, WR, DONE) and addr_bw default.
- No sub-module needed. The token rendezvous (toggle register plus compare) may optionally be a small tok_sync sub-module reused by other inter-core stages.

Test Plan:
- Solo, num_rows=3, start pulse → psum reads at addr 0,0,1,1,2,2.
  - acc and div each pulse 3 times.
  - Output writes to addr 0,1,2.
  - done exactly 20 cycles after start; busy high throughout.
- Two instances cross-connected, num_rows=4, second start delayed 5 cycles → first core waits in SYNC.
  - Both pass each SYNC together, and tok_out toggles 4 times on each core.
  - No acc on either core falls between the other core's SYNC exit and its DIV.
- num_rows=0 → done 2 cycles after start; psum_cen and out_cen stay 1.
- Reset asserted while in SYNC on row 2 of 5 → next cycle all outputs at reset values.
  - A new start then processes from row 0.
- start re-pulsed during a busy pass → ignored: row sequence and done timing unchanged, single done pulse.
- Checker over all tests:
  - acc and div never both high.
  - out_wen=0 only with out_cen=0.
  - Each out_addr written exactly once per pass.

Source files
------------

// File: rtl/norm_seq_pkg.sv
// norm_seq_pkg
// Shared definitions for the normalization row sequencer.
//   ADDR_BW_DEFAULT : default SRAM address width (max rows = 2**addr_bw)
//   state_t         : sequencer state encoding
package norm_seq_pkg;

   localparam int ADDR_BW_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_ACC = 3'd1,
      ACC    = 3'd2,
      SYNC   = 3'd3,
      RD_DIV = 3'd4,
      DIV    = 3'd5,
      WR     = 3'd6,
      DONE   = 3'd7
   } state_t;

endpackage

// File: rtl/norm_seq_tok_sync.sv
// norm_seq_tok_sync
// Two-phase token rendezvous between two cores. Each core flips its own token
// once per row; the row may proceed once the peer's token has caught up.
//   clk       : clock
//   reset     : synchronous active-high reset, token returns to 0
//   toggle_i  : flip the local token at the end of this cycle
//   tok_in_i  : token from the peer core
//   solo_i    : single-core mode, always report a match
//   tok_out_o : local token, driven to the peer core
//   match_o   : peer has reached the same row phase (or solo)
module norm_seq_tok_sync (
   input  logic clk,
   input  logic reset,
   input  logic toggle_i,
   input  logic tok_in_i,
   input  logic solo_i,
   output logic tok_out_o,
   output logic match_o
);

   logic tok_q;

   // Local token register; one flip per row marks "my row sum is latched".
   always_ff @(posedge clk) begin
      if (reset) begin
         tok_q <= 1'b0;
      end else if (toggle_i) begin
         tok_q <= ~tok_q;
      end
   end

   // Equal tokens mean both cores have latched the same number of row sums.
   assign tok_out_o = tok_q;
   assign match_o   = solo_i | (tok_in_i == tok_q);

endmodule

// File: rtl/norm_seq.sv
// norm_seq
// Row sequencer for the normalization stage of one core. For each row it reads
// the psum row and strobes acc, waits for the peer core to do the same, then
// rereads the row, strobes div and writes the normalized row to output SRAM.
//   clk       : clock
//   reset     : synchronous active-high reset
//   start     : one-cycle pulse, begins a pass when idle
//   num_rows  : rows in the pass (clamped to 2**addr_bw), captured with start
//   solo      : skip the peer rendezvous, captured with start
//   psum_cen  : psum SRAM chip enable (active-low), psum_addr its address
//   acc, div  : normalization stage accumulate / divide strobes
//   out_cen   : output SRAM chip enable (active-low)
//   out_wen   : output SRAM write enable (active-low), out_addr its address
//   tok_out   : row token to the peer core, tok_in : token from the peer
//   busy      : pass in progress, done : one-cycle end-of-pass pulse
module norm_seq
   import norm_seq_pkg::*;
#(
   parameter int addr_bw = ADDR_BW_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw:0]   num_rows,
   input  logic               solo,
   output logic               psum_cen,
   output logic [addr_bw-1:0] psum_addr,
   output logic               acc,
   output logic               div,
   output logic               out_cen,
   output logic               out_wen,
   output logic [addr_bw-1:0] out_addr,
   output logic               tok_out,
   input  logic               tok_in,
   output logic               busy,
   output logic               done
);

   localparam logic [addr_bw:0] MAX_ROWS = {1'b1, {addr_bw{1'b0}}};
   localparam logic [addr_bw-1:0] ROW_ONE = {{(addr_bw-1){1'b0}}, 1'b1};

   state_t             state_q;
   logic [addr_bw-1:0] row_q;
   logic [addr_bw-1:0] lastRow_q;
   logic               solo_q;
   logic               start_q;
   logic [addr_bw:0]   numRowsIn_q;
   logic               soloIn_q;

   logic               psumCen_q;
   logic [addr_bw-1:0] psumAddr_q;
   logic               acc_q;
   logic               div_q;
   logic               outCen_q;
   logic               outWen_q;
   logic [addr_bw-1:0] outAddr_q;
   logic               busy_q;
   logic               done_q;

   logic [addr_bw:0]   rowsClamped;
   logic [addr_bw-1:0] lastRow_d;
   logic [addr_bw-1:0] rowNext;
   logic               tokMatch;

   // Clamp the requested row count to the SRAM depth and derive the index of
   // the last row. A full-depth request has zero low bits, so the subtraction
   // wraps to the all-ones last index as intended.
   always_comb begin
      rowsClamped = numRowsIn_q;
      if (numRowsIn_q > MAX_ROWS) begin
         rowsClamped = MAX_ROWS;
      end
      lastRow_d = rowsClamped[addr_bw-1:0] - ROW_ONE;
      rowNext   = row_q + ROW_ONE;
   end

   // Peer rendezvous: the token flips on the edge that leaves ACC, which is
   // the same edge the normalization stage latches this row's sum.
   norm_seq_tok_sync u_tokSync (
      .clk       (clk),
      .reset     (reset),
      .toggle_i  (state_q == ACC),
      .tok_in_i  (tok_in),
      .solo_i    (solo_q),
      .tok_out_o (tok_out),
      .match_o   (tokMatch)
   );

   // Main sequencer. The start/num_rows/solo inputs pass through one register
   // stage before IDLE acts on them; every output is registered and set on the
   // transition into the state it belongs to. Strobes and enables default to
   // inactive each cycle so they only ever last a single state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         row_q       <= '0;
         lastRow_q   <= '0;
         solo_q      <= 1'b0;
         start_q     <= 1'b0;
         numRowsIn_q <= '0;
         soloIn_q    <= 1'b0;
         psumCen_q   <= 1'b1;
         psumAddr_q  <= '0;
         acc_q       <= 1'b0;
         div_q       <= 1'b0;
         outCen_q    <= 1'b1;
         outWen_q    <= 1'b1;
         outAddr_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         start_q     <= start;
         numRowsIn_q <= num_rows;
         soloIn_q    <= solo;
         psumCen_q   <= 1'b1;
         acc_q       <= 1'b0;
         div_q       <= 1'b0;
         outCen_q    <= 1'b1;
         outWen_q    <= 1'b1;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_q) begin
                  solo_q    <= soloIn_q;
                  lastRow_q <= lastRow_d;
                  row_q     <= '0;
                  if (rowsClamped == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= RD_ACC;
                     busy_q     <= 1'b1;
                     psumCen_q  <= 1'b0;
                     psumAddr_q <= '0;
                  end
               end
            end
            RD_ACC: begin
               state_q <= ACC;
               acc_q   <= 1'b1;
            end
            ACC: begin
               state_q <= SYNC;
            end
            SYNC: begin
               if (tokMatch) begin
                  state_q    <= RD_DIV;
                  psumCen_q  <= 1'b0;
                  psumAddr_q <= row_q;
               end
            end
            RD_DIV: begin
               state_q <= DIV;
               div_q   <= 1'b1;
            end
            DIV: begin
               state_q   <= WR;
               outCen_q  <= 1'b0;
               outWen_q  <= 1'b0;
               outAddr_q <= row_q;
            end
            WR: begin
               if (row_q == lastRow_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q    <= RD_ACC;
                  row_q      <= rowNext;
                  psumCen_q  <= 1'b0;
                  psumAddr_q <= rowNext;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign psum_cen  = psumCen_q;
   assign psum_addr = psumAddr_q;
   assign acc       = acc_q;
   assign div       = div_q;
   assign out_cen   = outCen_q;
   assign out_wen   = outWen_q;
   assign out_addr  = outAddr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
